// File: rtl/frame_scan_pkg.sv
// Shared types, default widths and the geometry check for the frame scan controller.
package frame_scan_pkg;

    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int FCNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_t;

    // Lines must be a non-zero multiple of 4 pixels so the packer emits full words.
    function automatic logic cfg_ok(input logic [31:0] width, input logic [31:0] height);
        return (width != 32'd0) && (width[1:0] == 2'b00) && (height != 32'd0);
    endfunction

endpackage

// File: rtl/frame_scan_controller_raster_counter.sv
// Raster-order x/y wrap counter; advances one pixel per handshake.
module raster_counter #(
    parameter int X_W = 11,
    parameter int Y_W = 10
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           clear,
    input  logic           advance,
    input  logic [X_W-1:0] width,
    input  logic [Y_W-1:0] height,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last_col,
    output logic           last_pix
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    assign last_col = (x_q == width - 1'b1);
    assign last_pix = last_col && (y_q == height - 1'b1);
    assign x        = x_q;
    assign y        = y_q;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (last_col) begin
                x_d = '0;
                y_d = last_pix ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // NOTE: reset is sampled on the clock edge (synchronous), and state uses non-blocking assignments.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/frame_scan_controller.sv
// Frame sequencer: start/stop/continuous control, geometry latching and frame counting.
module frame_scan_controller #(
    parameter int X_W    = frame_scan_pkg::X_W,
    parameter int Y_W    = frame_scan_pkg::Y_W,
    parameter int FCNT_W = frame_scan_pkg::FCNT_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [X_W-1:0]    cfg_width,
    input  logic [Y_W-1:0]    cfg_height,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic              pix_valid,
    output logic              pix_sof,
    output logic              pix_eol,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err,
    output logic [FCNT_W-1:0] frame_count
);

    import frame_scan_pkg::*;

    scan_state_t       state_q, state_d;
    logic [X_W-1:0]    width_q, width_d;
    logic [Y_W-1:0]    height_q, height_d;
    logic              stop_pend_q, stop_pend_d;
    logic              cfg_err_q, cfg_err_d;
    logic              frame_done_q, frame_done_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;

    logic clear_cnt;
    logic handshake;
    logic last_col;
    logic last_pix;
    logic live_cfg_ok;

    raster_counter #(
        .X_W(X_W),
        .Y_W(Y_W)
    ) u_raster (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (clear_cnt),
        .advance (handshake),
        .width   (width_q),
        .height  (height_q),
        .x       (pix_x),
        .y       (pix_y),
        .last_col(last_col),
        .last_pix(last_pix)
    );

    assign pix_valid   = (state_q == RUN);
    assign busy        = (state_q == RUN);
    assign handshake   = pix_valid && pix_ready;
    assign pix_sof     = pix_valid && (pix_x == '0) && (pix_y == '0);
    assign pix_eol     = pix_valid && last_col;
    assign frame_done  = frame_done_q;
    assign cfg_err     = cfg_err_q;
    assign frame_count = frame_count_q;
    assign live_cfg_ok = cfg_ok(32'(cfg_width), 32'(cfg_height));

    always_comb begin
        state_d       = state_q;
        width_d       = width_q;
        height_d      = height_q;
        stop_pend_d   = stop_pend_q;
        cfg_err_d     = cfg_err_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        clear_cnt     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (live_cfg_ok) begin
                        state_d     = RUN;
                        width_d     = cfg_width;
                        height_d    = cfg_height;
                        stop_pend_d = 1'b0;
                        cfg_err_d   = 1'b0;
                        clear_cnt   = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (handshake && last_pix) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 1'b1;
                    // The counter wraps to (0,0) on its own, so a restart needs no clear.
                    if (continuous && !stop_pend_q && !stop) begin
                        if (live_cfg_ok) begin
                            width_d  = cfg_width;
                            height_d = cfg_height;
                        end else begin
                            cfg_err_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            width_q       <= '0;
            height_q      <= '0;
            stop_pend_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            width_q       <= width_d;
            height_q      <= height_d;
            stop_pend_q   <= stop_pend_d;
            cfg_err_q     <= cfg_err_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_frame_scan_controller.sv
// Self-checking bench: observed handshakes are compared against raster order computed arithmetically.
module tb_frame_scan_controller;

    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int FCNT_W = 16;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [X_W-1:0]    cfg_width;
    logic [Y_W-1:0]    cfg_height;
    logic              start;
    logic              continuous;
    logic              stop;
    logic [X_W-1:0]    pix_x;
    logic [Y_W-1:0]    pix_y;
    logic              pix_valid;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_ready;
    logic              busy;
    logic              frame_done;
    logic              cfg_err;
    logic [FCNT_W-1:0] frame_count;

    always #5 aclk = ~aclk;

    frame_scan_controller #(
        .X_W(X_W), .Y_W(Y_W), .FCNT_W(FCNT_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .start(start), .continuous(continuous), .stop(stop),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_ready(pix_ready),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
        .frame_count(frame_count)
    );

    typedef struct {
        int x;
        int y;
        bit sof;
        bit eol;
        int cyc;
    } hs_t;

    int  checks   = 0;
    int  failures = 0;
    hs_t hs_q[$];
    int  done_cyc[$];
    int  cyc;
    int  stall_viol;
    int  valid_cycles;
    bit  prev_stall;
    int  px, py;
    bit  psof, peol;

    task automatic clear_obs();
        hs_q.delete();
        done_cyc.delete();
        stall_viol   = 0;
        valid_cycles = 0;
        prev_stall   = 1'b0;
    endtask

    // Sample outputs #1 after an edge, record handshakes and stall stability, then advance one clock.
    task automatic step(input int ready_pct);
        hs_t h;
        pix_ready = ($urandom_range(99) < ready_pct);
        if (prev_stall) begin
            if (!pix_valid || int'(pix_x) != px || int'(pix_y) != py || pix_sof != psof || pix_eol != peol)
                stall_viol++;
        end
        prev_stall = pix_valid && !pix_ready;
        px = int'(pix_x); py = int'(pix_y); psof = pix_sof; peol = pix_eol;
        if (pix_valid) valid_cycles++;
        if (pix_valid && pix_ready) begin
            h.x = int'(pix_x); h.y = int'(pix_y); h.sof = pix_sof; h.eol = pix_eol; h.cyc = cyc;
            hs_q.push_back(h);
        end
        if (frame_done) done_cyc.push_back(cyc);
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    // Index of the first handshake deviating from raster order of a w x h frame stream, or -1.
    function automatic int first_mismatch(input int w, input int h);
        for (int i = 0; i < hs_q.size(); i++) begin
            int ex, ey;
            ex = i % w;
            ey = (i / w) % h;
            if (hs_q[i].x != ex || hs_q[i].y != ey || hs_q[i].sof != (ex == 0 && ey == 0) || hs_q[i].eol != (ex == w - 1))
                return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        aresetn = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; pix_ready = 1'b0;
        cfg_width = '0; cfg_height = '0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        clear_obs();
    endtask

    task automatic launch(input int w, input int h);
        cfg_width = X_W'(w); cfg_height = Y_W'(h); start = 1'b1;
        step(0);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        checks++;
        if ({pix_valid, busy, frame_done, cfg_err, pix_sof, pix_eol, pix_x, pix_y} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b busy=%b done=%b err=%b sof=%b eol=%b x=%0d y=%0d, required all 0",
                     pix_valid, busy, frame_done, cfg_err, pix_sof, pix_eol, pix_x, pix_y);
        end
        checks++;
        if (frame_count !== '0) begin
            failures++;
            $display("FAIL reset_frame_count: got %0d, required 0", frame_count);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_basic();
        int start_cyc;
        int mm;
        do_reset();
        start_cyc = cyc;
        launch(8, 2);
        repeat (40) step(100);
        mm = first_mismatch(8, 2);
        checks++;
        if (hs_q.size() != 16 || mm != -1) begin
            failures++;
            $display("FAIL basic_pixels: handshakes=%0d first_bad=%0d, required 16 and -1", hs_q.size(), mm);
        end
        checks++;
        if (hs_q.size() == 0 || hs_q[0].cyc != start_cyc + 1) begin
            failures++;
            $display("FAIL basic_latency: first handshake cycle=%0d, required %0d",
                     hs_q.size() ? hs_q[0].cyc : -1, start_cyc + 1);
        end
        checks++;
        if (done_cyc.size() != 1 || hs_q.size() != 16 || done_cyc[0] != hs_q[15].cyc + 1) begin
            failures++;
            $display("FAIL basic_done: pulses=%0d first=%0d, required 1 pulse one cycle after last pixel",
                     done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
        end
        checks++;
        if (frame_count !== FCNT_W'(1) || busy !== 1'b0 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_end_state: count=%0d busy=%b valid=%b, required 1 0 0", frame_count, busy, pix_valid);
        end
    endtask

    task automatic test_backpressure();
        int mm;
        do_reset();
        launch(8, 2);
        repeat (200) step(50);
        mm = first_mismatch(8, 2);
        checks++;
        if (hs_q.size() != 16 || mm != -1) begin
            failures++;
            $display("FAIL bp_pixels: handshakes=%0d first_bad=%0d, required 16 and -1", hs_q.size(), mm);
        end
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL bp_stable: stall violations=%0d, required 0", stall_viol);
        end
        checks++;
        if (done_cyc.size() != 1 || frame_count !== FCNT_W'(1)) begin
            failures++;
            $display("FAIL bp_done: pulses=%0d count=%0d, required 1 and 1", done_cyc.size(), frame_count);
        end
    endtask

    task automatic test_cfg_err();
        int mm;
        do_reset();
        launch(6, 2);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cfg_width6: err=%b busy=%b, required 1 0", cfg_err, busy);
        end
        launch(8, 0);
        repeat (5) step(100);
        checks++;
        if (cfg_err !== 1'b1 || valid_cycles != 0) begin
            failures++;
            $display("FAIL cfg_height0: err=%b valid_cycles=%0d, required 1 0", cfg_err, valid_cycles);
        end
        launch(4, 1);
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cfg_clear: err=%b busy=%b, required 0 1", cfg_err, busy);
        end
        repeat (10) step(100);
        mm = first_mismatch(4, 1);
        checks++;
        if (hs_q.size() != 4 || mm != -1 || frame_count !== FCNT_W'(1)) begin
            failures++;
            $display("FAIL cfg_run4x1: handshakes=%0d first_bad=%0d count=%0d, required 4 -1 1",
                     hs_q.size(), mm, frame_count);
        end
    endtask

    task automatic test_continuous_stop();
        int mm;
        bit contiguous;
        bit done_ok;
        do_reset();
        continuous = 1'b1;
        launch(4, 2);
        for (int i = 0; i < 60; i++) begin
            stop = (hs_q.size() == 18);
            step(100);
        end
        stop = 1'b0;
        continuous = 1'b0;
        mm = first_mismatch(4, 2);
        checks++;
        if (hs_q.size() != 24 || mm != -1) begin
            failures++;
            $display("FAIL cont_pixels: handshakes=%0d first_bad=%0d, required 24 -1", hs_q.size(), mm);
        end
        contiguous = (hs_q.size() == 24);
        for (int i = 0; i < hs_q.size(); i++)
            if (hs_q[i].cyc != hs_q[0].cyc + i) contiguous = 1'b0;
        checks++;
        if (!contiguous) begin
            failures++;
            $display("FAIL cont_no_bubble: handshake cycles not contiguous (count=%0d), required 24 back to back", hs_q.size());
        end
        done_ok = (done_cyc.size() == 3) && (hs_q.size() == 24);
        if (done_ok)
            for (int k = 0; k < 3; k++)
                if (done_cyc[k] != hs_q[8 * k + 7].cyc + 1) done_ok = 1'b0;
        checks++;
        if (!done_ok || frame_count !== FCNT_W'(3) || busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_done: pulses=%0d count=%0d busy=%b, required 3 aligned pulses, 3, 0",
                     done_cyc.size(), frame_count, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int mm;
        do_reset();
        launch(8, 2);
        n = 0;
        while (!(pix_valid && pix_x == X_W'(5) && pix_y == Y_W'(0)) && n < 20) begin
            step(100);
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL midrst_reach: pixel (5,0) not presented within 20 cycles, got x=%0d y=%0d", pix_x, pix_y);
        end
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        checks++;
        if ({pix_valid, busy, frame_done, pix_sof, pix_eol, pix_x, pix_y, frame_count} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: valid=%b busy=%b done=%b x=%0d y=%0d count=%0d, required all 0",
                     pix_valid, busy, frame_done, pix_x, pix_y, frame_count);
        end
        aresetn = 1'b1;
        clear_obs();
        repeat (20) step(100);
        checks++;
        if (valid_cycles != 0 || done_cyc.size() != 0) begin
            failures++;
            $display("FAIL midrst_quiet: valid_cycles=%0d done_pulses=%0d, required 0 0", valid_cycles, done_cyc.size());
        end
        launch(8, 2);
        repeat (30) step(100);
        mm = first_mismatch(8, 2);
        checks++;
        if (hs_q.size() != 16 || mm != -1 || frame_count !== FCNT_W'(1)) begin
            failures++;
            $display("FAIL midrst_restart: handshakes=%0d first_bad=%0d count=%0d, required 16 -1 1",
                     hs_q.size(), mm, frame_count);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cfg_width = X_W'(8); cfg_height = Y_W'(2);
        start = 1'b1; stop = 1'b1;
        step(100);
        start = 1'b0; stop = 1'b0;
        repeat (10) step(100);
        checks++;
        if (valid_cycles != 0 || cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL sim_start_stop: valid_cycles=%0d err=%b, required 0 0", valid_cycles, cfg_err);
        end
        clear_obs();
        continuous = 1'b1;
        launch(4, 2);
        for (int i = 0; i < 30; i++) begin
            stop = pix_valid && (pix_x == X_W'(3)) && (pix_y == Y_W'(1));
            step(100);
        end
        stop = 1'b0;
        continuous = 1'b0;
        checks++;
        if (hs_q.size() != 8 || done_cyc.size() != 1 || frame_count !== FCNT_W'(1) || busy !== 1'b0) begin
            failures++;
            $display("FAIL sim_stop_last: handshakes=%0d pulses=%0d count=%0d busy=%b, required 8 1 1 0",
                     hs_q.size(), done_cyc.size(), frame_count, busy);
        end
    endtask

    task automatic test_random_geometry();
        for (int t = 0; t < 4; t++) begin
            int w, h, mm;
            logic [FCNT_W-1:0] fc_before;
            w = 4 * $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            clear_obs();
            fc_before = frame_count;
            launch(w, h);
            repeat (4 * w * h + 50) step(60);
            mm = first_mismatch(w, h);
            checks++;
            if (hs_q.size() != w * h || mm != -1 || stall_viol != 0 || frame_count !== fc_before + 1'b1) begin
                failures++;
                $display("FAIL rand_%0dx%0d: handshakes=%0d first_bad=%0d stall_viol=%0d count=%0d, required %0d -1 0 %0d",
                         w, h, hs_q.size(), mm, stall_viol, frame_count, w * h, fc_before + 1'b1);
            end
        end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_err();
        test_continuous_stop();
        test_reset_mid_frame();
        test_simultaneous();
        test_random_geometry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
